// File: rtl/tx_pkg.sv
// Shared types and constants for the TX FIFO write-port arbiter.
package tx_pkg;

  localparam int DATA_W_DEF = 512;
  localparam int FLAG_W_DEF = DATA_W_DEF / 8;
  localparam int STARVE_W   = 4;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_TLP  = 2'b01;
  localparam logic [1:0] GRANT_DLLP = 2'b10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OWN_TLP  = 2'd1,
    OWN_DLLP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/tx_arb_starve_cnt.sv
// Saturating count of consecutive contested DLLP grants; clear wins over increment.
module tx_arb_starve_cnt #(
  parameter int MAX = 4,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign at_max = (cnt_q == W'(MAX));
  assign cnt    = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !at_max) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tx_write_arbiter.sv
// Packet-atomic TLP/DLLP arbiter in front of the TX FIFO write port.
// Optional stall watchdog and wd_abort port: define TX_ARB_WATCHDOG_EN.
module tx_write_arbiter
  import tx_pkg::*;
#(
  parameter int DATA_W         = DATA_W_DEF,
  parameter int FLAG_W         = FLAG_W_DEF,
  parameter int MAX_DLLP_BURST = 4
) (
  input  logic              pclk,
  input  logic              reset,
  input  logic              tx_enable,
  input  logic [DATA_W-1:0] tlp_data,
  input  logic [FLAG_W-1:0] tlp_valid,
  input  logic [FLAG_W-1:0] tlp_stp,
  input  logic [FLAG_W-1:0] tlp_end,
  input  logic              tlp_vld,
  output logic              tlp_rdy,
  input  logic [DATA_W-1:0] dllp_data,
  input  logic [FLAG_W-1:0] dllp_valid,
  input  logic [FLAG_W-1:0] dllp_sdp,
  input  logic [FLAG_W-1:0] dllp_end,
  input  logic              dllp_vld,
  output logic              dllp_rdy,
  input  logic              fifo_full,
  output logic              fifo_wr,
  output logic [DATA_W-1:0] fifo_data,
  output logic [FLAG_W-1:0] fifo_valid,
  output logic [FLAG_W-1:0] fifo_stp,
  output logic [FLAG_W-1:0] fifo_sdp,
  output logic [FLAG_W-1:0] fifo_end,
  output logic [1:0]        grant,
`ifdef TX_ARB_WATCHDOG_EN
  output logic              wd_abort,
`endif
  output logic              proto_err
);

  // Handshake: a beat moves when owner vld & rdy; rdy depends only on ownership and fifo_full.
  arb_state_e state_q, state_d;
  logic first_q, first_d;
  logic perr_q, perr_d;
  logic cnt_clr, cnt_inc, cnt_at_max;
  logic [STARVE_W-1:0] cnt_unused;

  logic own_tlp, own_dllp, owner_vld, owner_start, owner_end;

  tx_arb_starve_cnt #(.MAX(MAX_DLLP_BURST), .W(STARVE_W)) u_starve (
    .clk    (pclk),
    .reset  (reset),
    .clr    (cnt_clr),
    .inc    (cnt_inc),
    .cnt    (cnt_unused),
    .at_max (cnt_at_max)
  );

  assign own_tlp     = (state_q == OWN_TLP);
  assign own_dllp    = (state_q == OWN_DLLP);
  assign owner_vld   = (own_tlp & tlp_vld) | (own_dllp & dllp_vld);
  assign owner_start = own_tlp ? |tlp_stp : |dllp_sdp;
  assign owner_end   = own_tlp ? |tlp_end : |dllp_end;

  assign tlp_rdy   = own_tlp & ~fifo_full;
  assign dllp_rdy  = own_dllp & ~fifo_full;
  assign fifo_wr   = owner_vld & ~fifo_full;
  assign grant     = own_tlp ? GRANT_TLP : (own_dllp ? GRANT_DLLP : GRANT_NONE);
  assign proto_err = perr_q;

  // Buses are zeroed on non-write cycles so downstream never sees stale framing.
  always_comb begin
    fifo_data  = '0;
    fifo_valid = '0;
    fifo_stp   = '0;
    fifo_sdp   = '0;
    fifo_end   = '0;
    if (fifo_wr && own_tlp) begin
      fifo_data  = tlp_data;
      fifo_valid = tlp_valid;
      fifo_stp   = tlp_stp;
      fifo_end   = tlp_end;
    end else if (fifo_wr && own_dllp) begin
      fifo_data  = dllp_data;
      fifo_valid = dllp_valid;
      fifo_sdp   = dllp_sdp;
      fifo_end   = dllp_end;
    end
  end

`ifdef TX_ARB_WATCHDOG_EN
  logic [7:0] stall_q, stall_d;
  logic       wd_q, wd_d;
  assign wd_abort = wd_q;
`endif

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    perr_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
`ifdef TX_ARB_WATCHDOG_EN
    stall_d = '0;
    wd_d    = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (tx_enable) begin
          // DLLP wins unless a waiting TLP has already lost MAX_DLLP_BURST times.
          if (dllp_vld && (!tlp_vld || !cnt_at_max)) begin
            state_d = OWN_DLLP;
            first_d = 1'b1;
            cnt_inc = tlp_vld;
          end else if (tlp_vld) begin
            state_d = OWN_TLP;
            first_d = 1'b1;
            cnt_clr = 1'b1;
          end
        end
      end
      OWN_TLP, OWN_DLLP: begin
        if (fifo_wr) begin
          first_d = 1'b0;
          perr_d  = first_q & ~owner_start;
          if (owner_end) begin
            state_d = IDLE;
          end
        end
`ifdef TX_ARB_WATCHDOG_EN
        if (fifo_wr) begin
          stall_d = '0;
        end else if (!owner_vld) begin
          stall_d = stall_q + 8'd1;
        end else begin
          stall_d = stall_q;
        end
        if (stall_q == 8'hFF) begin
          state_d = IDLE;
          stall_d = '0;
          wd_d    = 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      state_q <= IDLE;
      first_q <= 1'b0;
      perr_q  <= 1'b0;
`ifdef TX_ARB_WATCHDOG_EN
      stall_q <= '0;
      wd_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      perr_q  <= perr_d;
`ifdef TX_ARB_WATCHDOG_EN
      stall_q <= stall_d;
      wd_q    <= wd_d;
`endif
    end
  end

endmodule

// File: tb/tb_tx_write_arbiter.sv
// Table-driven bench for tx_write_arbiter plus hand sequences for stalls and the watchdog.
module tb_tx_write_arbiter;

  localparam int DATA_W = 512;
  localparam int FLAG_W = 64;
  localparam logic [FLAG_W-1:0] END_FLAG = 64'h8000_0000_0000_0000;
  localparam logic [FLAG_W-1:0] STP_FLAG = 64'h1;
  localparam logic [FLAG_W-1:0] DLLP_BV  = 64'hFF;

  logic              pclk = 1'b0;
  logic              reset;
  logic              tx_enable;
  logic [DATA_W-1:0] tlp_data;
  logic [FLAG_W-1:0] tlp_valid, tlp_stp, tlp_end;
  logic              tlp_vld, tlp_rdy;
  logic [DATA_W-1:0] dllp_data;
  logic [FLAG_W-1:0] dllp_valid, dllp_sdp, dllp_end;
  logic              dllp_vld, dllp_rdy;
  logic              fifo_full, fifo_wr;
  logic [DATA_W-1:0] fifo_data;
  logic [FLAG_W-1:0] fifo_valid, fifo_stp, fifo_sdp, fifo_end;
  logic [1:0]        grant;
  logic              proto_err;
`ifdef TX_ARB_WATCHDOG_EN
  logic              wd_abort;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  tx_write_arbiter #(.DATA_W(DATA_W), .FLAG_W(FLAG_W), .MAX_DLLP_BURST(4)) dut (
    .pclk       (pclk),
    .reset      (reset),
    .tx_enable  (tx_enable),
    .tlp_data   (tlp_data),
    .tlp_valid  (tlp_valid),
    .tlp_stp    (tlp_stp),
    .tlp_end    (tlp_end),
    .tlp_vld    (tlp_vld),
    .tlp_rdy    (tlp_rdy),
    .dllp_data  (dllp_data),
    .dllp_valid (dllp_valid),
    .dllp_sdp   (dllp_sdp),
    .dllp_end   (dllp_end),
    .dllp_vld   (dllp_vld),
    .dllp_rdy   (dllp_rdy),
    .fifo_full  (fifo_full),
    .fifo_wr    (fifo_wr),
    .fifo_data  (fifo_data),
    .fifo_valid (fifo_valid),
    .fifo_stp   (fifo_stp),
    .fifo_sdp   (fifo_sdp),
    .fifo_end   (fifo_end),
    .grant      (grant),
`ifdef TX_ARB_WATCHDOG_EN
    .wd_abort   (wd_abort),
`endif
    .proto_err  (proto_err)
  );

  // Clock / reset
  always #5 pclk = ~pclk;

  typedef struct {
    logic       en, rst, tv, ts, te, dv, ds, de, full;
    logic [1:0] g;
    logic       wr, trdy, drdy, perr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic en, logic rst, logic tv, logic ts, logic te,
                              logic dv, logic ds, logic de, logic full,
                              logic [1:0] g, logic wr, logic trdy, logic drdy, logic perr);
    vec_t v;
    v.en = en; v.rst = rst; v.tv = tv; v.ts = ts; v.te = te;
    v.dv = dv; v.ds = ds; v.de = de; v.full = full;
    v.g = g; v.wr = wr; v.trdy = trdy; v.drdy = drdy; v.perr = perr;
    return v;
  endfunction

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver
  task automatic drive(input vec_t v, input int idx);
    logic [7:0] id8;
    id8        = idx[7:0];
    reset      = v.rst;
    tx_enable  = v.en;
    tlp_vld    = v.tv;
    tlp_stp    = v.ts ? STP_FLAG : '0;
    tlp_end    = v.te ? END_FLAG : '0;
    tlp_valid  = '1;
    tlp_data   = {16{24'hA0B0C0, id8}};
    dllp_vld   = v.dv;
    dllp_sdp   = v.ds ? STP_FLAG : '0;
    dllp_end   = v.de ? END_FLAG : '0;
    dllp_valid = DLLP_BV;
    dllp_data  = {16{24'hD0E0F0, id8}};
    fifo_full  = v.full;
  endtask

  // Scoreboard: expected buses follow from the expected owner and write strobe.
  task automatic check_vec(input vec_t v, input int idx);
    logic [DATA_W-1:0] e_data;
    logic [FLAG_W-1:0] e_valid, e_stp, e_sdp, e_end;
    e_data = '0; e_valid = '0; e_stp = '0; e_sdp = '0; e_end = '0;
    if (v.wr && v.g == 2'b01) begin
      e_data = tlp_data; e_valid = tlp_valid; e_stp = tlp_stp; e_end = tlp_end;
    end else if (v.wr && v.g == 2'b10) begin
      e_data = dllp_data; e_valid = dllp_valid; e_sdp = dllp_sdp; e_end = dllp_end;
    end
    chk($sformatf("v%0d grant", idx), DATA_W'(grant), DATA_W'(v.g));
    chk($sformatf("v%0d fifo_wr", idx), DATA_W'(fifo_wr), DATA_W'(v.wr));
    chk($sformatf("v%0d tlp_rdy", idx), DATA_W'(tlp_rdy), DATA_W'(v.trdy));
    chk($sformatf("v%0d dllp_rdy", idx), DATA_W'(dllp_rdy), DATA_W'(v.drdy));
    chk($sformatf("v%0d proto_err", idx), DATA_W'(proto_err), DATA_W'(v.perr));
    chk($sformatf("v%0d fifo_data", idx), fifo_data, e_data);
    chk($sformatf("v%0d fifo_valid", idx), DATA_W'(fifo_valid), DATA_W'(e_valid));
    chk($sformatf("v%0d fifo_stp", idx), DATA_W'(fifo_stp), DATA_W'(e_stp));
    chk($sformatf("v%0d fifo_sdp", idx), DATA_W'(fifo_sdp), DATA_W'(e_sdp));
    chk($sformatf("v%0d fifo_end", idx), DATA_W'(fifo_end), DATA_W'(e_end));
  endtask

  task automatic step(input vec_t v, input int idx);
    @(posedge pclk);
    #1;
    drive(v, idx);
    #1;
    check_vec(v, idx);
  endtask

  initial begin
    int base;
    bit seen;

    // Single-beat TLP
    vecs.push_back(mk(1,0, 1,1,1, 0,0,0, 0, 2'b00,0,0,0,0));
    vecs.push_back(mk(1,0, 1,1,1, 0,0,0, 0, 2'b01,1,1,0,0));
    vecs.push_back(mk(1,0, 0,0,0, 0,0,0, 0, 2'b00,0,0,0,0));
    // DLLP without SDP on its first beat
    vecs.push_back(mk(1,0, 0,0,0, 1,0,1, 0, 2'b00,0,0,0,0));
    vecs.push_back(mk(1,0, 0,0,0, 1,0,1, 0, 2'b10,1,0,1,0));
    vecs.push_back(mk(1,0, 0,0,0, 0,0,0, 0, 2'b00,0,0,0,1));
    vecs.push_back(mk(1,0, 0,0,0, 0,0,0, 0, 2'b00,0,0,0,0));
    // 3-beat TLP, FIFO full for 5 cycles on beat 2, DLLP waiting
    vecs.push_back(mk(1,0, 1,1,0, 0,0,0, 0, 2'b00,0,0,0,0));
    vecs.push_back(mk(1,0, 1,1,0, 1,1,1, 0, 2'b01,1,1,0,0));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(1,0, 1,0,0, 1,1,1, 1, 2'b01,0,0,0,0));
    vecs.push_back(mk(1,0, 1,0,0, 1,1,1, 0, 2'b01,1,1,0,0));
    vecs.push_back(mk(1,0, 1,0,1, 1,1,1, 0, 2'b01,1,1,0,0));
    // Multi-beat DLLP interrupted by reset
    vecs.push_back(mk(1,0, 0,0,0, 1,1,0, 0, 2'b00,0,0,0,0));
    vecs.push_back(mk(1,0, 0,0,0, 1,1,0, 0, 2'b10,1,0,1,0));
    vecs.push_back(mk(1,1, 0,0,0, 1,0,0, 0, 2'b10,1,0,1,0));
    // Both requesters always valid: D,D,D,D,T,D with idle bubbles
    base = vecs.size();
    for (int k = 0; k < 6; k++) begin
      vecs.push_back(mk(1,0, 1,1,1, 1,1,1, 0, 2'b00,0,0,0,0));
      if (k == 4) vecs.push_back(mk(1,0, 1,1,1, 1,1,1, 0, 2'b01,1,1,0,0));
      else        vecs.push_back(mk(1,0, 1,1,1, 1,1,1, 0, 2'b10,1,0,1,0));
    end
    // tx_enable drops during beat 2 of a 4-beat TLP
    vecs.push_back(mk(1,0, 1,1,0, 0,0,0, 0, 2'b00,0,0,0,0));
    vecs.push_back(mk(1,0, 1,1,0, 1,1,1, 0, 2'b01,1,1,0,0));
    vecs.push_back(mk(0,0, 1,0,0, 1,1,1, 0, 2'b01,1,1,0,0));
    vecs.push_back(mk(0,0, 1,0,0, 1,1,1, 0, 2'b01,1,1,0,0));
    vecs.push_back(mk(0,0, 1,0,1, 1,1,1, 0, 2'b01,1,1,0,0));
    vecs.push_back(mk(0,0, 1,1,1, 1,1,1, 0, 2'b00,0,0,0,0));
    vecs.push_back(mk(0,0, 1,1,1, 1,1,1, 0, 2'b00,0,0,0,0));

    // Reset with requests pending: outputs stay quiet
    drive(mk(1,1, 1,1,1, 1,1,1, 0, 2'b00,0,0,0,0), 255);
    repeat (3) begin
      @(posedge pclk);
      #2;
      chk("reset grant", DATA_W'(grant), '0);
      chk("reset fifo_wr", DATA_W'(fifo_wr), '0);
      chk("reset rdy", DATA_W'({tlp_rdy, dllp_rdy}), '0);
      chk("reset proto_err", DATA_W'(proto_err), '0);
      chk("reset fifo_data", fifo_data, '0);
    end

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], i);
    if (base == 0) $display("FAIL table build: burst section missing");

    // Owner vld low mid-packet: ownership held, nothing written
    step(mk(1,0, 0,0,0, 1,1,0, 0, 2'b00,0,0,0,0), 100);
    step(mk(1,0, 0,0,0, 1,1,0, 0, 2'b10,1,0,1,0), 101);
    for (int k = 0; k < 10; k++)
      step(mk(1,0, 1,1,1, 0,0,0, 0, 2'b10,0,0,1,0), 102 + k);
    step(mk(1,0, 0,0,0, 1,0,1, 0, 2'b10,1,0,1,0), 112);
    step(mk(1,0, 0,0,0, 0,0,0, 0, 2'b00,0,0,0,0), 113);

`ifdef TX_ARB_WATCHDOG_EN
    // Watchdog: owner stalls until abort
    step(mk(1,0, 0,0,0, 1,1,0, 0, 2'b00,0,0,0,0), 120);
    step(mk(1,0, 0,0,0, 1,1,0, 0, 2'b10,1,0,1,0), 121);
    drive(mk(1,0, 0,0,0, 0,0,0, 0, 2'b00,0,0,0,0), 122);
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(posedge pclk);
      #2;
      if (wd_abort === 1'b1) seen = 1'b1;
    end
    chk("wd_abort seen", DATA_W'(seen), DATA_W'(1));
    chk("wd grant", DATA_W'(grant), '0);
    @(posedge pclk);
    #2;
    chk("wd_abort pulse", DATA_W'(wd_abort), '0);
`else
    seen = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tx_write_arbiter.md
Name: tx_write_arbiter

Overview:
Packet-atomic arbiter sharing the TX FIFO write port between two requesters: TLPs from the transaction layer and DLLPs (ACK/NAK, FC updates) from the data link layer.
- Sits directly upstream of TX_CONTROL's FIFO write interface.
- Drives wr / data / byte-valid / STP / SDP / END and honours the FIFO full flag.
- DLLPs have priority; a starvation counter guarantees TLP forward progress.

Parameters:
DATA_W, 512, write-port data width in bits
FLAG_W, 64, byte-valid / framing flag width (DATA_W/8)
MAX_DLLP_BURST, 4, max consecutive contested DLLP grants before a waiting TLP is forced through (1..15)

Ports:
pclk  in  1  clock; all logic rising-edge
reset  in  1  synchronous, active-high reset
tx_enable  in  1  1 = new packets may be granted
tlp_data  in  DATA_W  TLP beat data
tlp_valid  in  FLAG_W  TLP byte valids
tlp_stp  in  FLAG_W  STP token position flags
tlp_end  in  FLAG_W  END position flags
tlp_vld  in  1  TLP beat present
tlp_rdy  out  1  TLP beat accepted when tlp_vld&tlp_rdy
dllp_data  in  DATA_W  DLLP beat data
dllp_valid  in  FLAG_W  DLLP byte valids
dllp_sdp  in  FLAG_W  SDP token position flags
dllp_end  in  FLAG_W  END position flags
dllp_vld  in  1  DLLP beat present
dllp_rdy  out  1  DLLP beat accepted
fifo_full  in  1  FIFO full
fifo_wr  out  1  FIFO write strobe
fifo_data  out  DATA_W  write data
fifo_valid  out  FLAG_W  write byte valids
fifo_stp  out  FLAG_W  STP flags
fifo_sdp  out  FLAG_W  SDP flags
fifo_end  out  FLAG_W  END flags
grant  out  2  one-hot owner: [0]=TLP, [1]=DLLP; 0 = idle
proto_err  out  1  one-cycle pulse: first beat of a packet lacks a start flag

Behaviour:
- Registered state: IDLE, OWN_TLP, OWN_DLLP.
- Reset values: state IDLE; grant 0; starvation count 0; proto_err 0. With grant=0: fifo_wr, tlp_rdy, dllp_rdy = 0 and all fifo_* buses = 0.
- IDLE arbitration (evaluated only when tx_enable=1):
  - dllp_vld only -> OWN_DLLP.
  - tlp_vld only -> OWN_TLP.
  - Both valid and count<MAX_DLLP_BURST -> OWN_DLLP, count++.
  - Both valid and count==MAX_DLLP_BURST -> OWN_TLP.
  - Any TLP grant clears count.
  - tx_enable=0 -> remain IDLE.
- The IDLE cycle transfers nothing: 1-cycle arbitration bubble per packet.
- Owning states:
  - rdy(owner) = !fifo_full; other rdy = 0.
  - fifo_wr = owner_vld & !fifo_full. Datapath is combinational: zero latency from owner inputs to fifo_* outputs.
  - fifo_stp = tlp_stp when TLP owns, else 0. fifo_sdp = dllp_sdp when DLLP owns, else 0.
  - All fifo_* buses are forced to 0 whenever fifo_wr=0.
- Packet end: an accepted beat with |end != 0 returns to IDLE next cycle. A single-beat packet (start and END in the same beat) is legal.
- Stalls:
  - fifo_full mid-packet: state held, no write.
  - Owner vld low mid-packet: state held, no write, no timeout (unless the optional feature is compiled in).
- tx_enable falling mid-packet: the current packet completes; no new grant afterwards.
- proto_err: pulses the cycle after an accepted first beat whose start flags (stp for TLP, sdp for DLLP) are all 0. The packet is still forwarded.
- Simultaneous END accept and new request: the new request is arbitrated in the following IDLE cycle.
- Reset mid-packet: IDLE next cycle; packet truncated. Upstream flush is the requester's responsibility.

Optional Feature:
TX_ARB_WATCHDOG_EN
- Defined: 8-bit stall counter increments each owning cycle with owner_vld=0 and clears on any accepted beat. At 255 the arbiter forces IDLE and pulses output wd_abort for 1 cycle (port exists only when defined).
- Undefined: no counter, no port; ownership is held indefinitely.

Decomposition:
- Shared package tx_pkg:
  - state enum {IDLE, OWN_TLP, OWN_DLLP}
  - GRANT_TLP=2'b01, GRANT_DLLP=2'b10
  - FLAG_W/DATA_W defaults
- Natural sub-module: tx_arb_starve_cnt (saturating counter with clear/inc/at_max). Datapath mux stays inline.

Test Plan:
- Reset, then single-beat TLP (tlp_stp=1, tlp_end=64'h8000_0000_0000_0000) -> grant=01 on cycle 2; fifo_wr=1 for exactly 1 cycle with fifo_data=tlp_data; grant=0 on cycle 3.
- Both requesters continuously valid, single-beat packets, MAX_DLLP_BURST=4 -> grant sequence DLLP,DLLP,DLLP,DLLP,TLP repeating, each separated by one idle cycle.
- 3-beat TLP with fifo_full=1 during beat 2 for 5 cycles -> tlp_rdy=0 and fifo_wr=0 for those 5 cycles, dllp_rdy=0 throughout, beats written in order, no interleaved DLLP.
- tx_enable dropped during beat 2 of a 4-beat TLP -> all 4 beats written, then grant stays 0 while tlp_vld/dllp_vld remain high.
- DLLP first beat with dllp_sdp=0 -> beat written, proto_err=1 for exactly the next cycle.
- reset=1 asserted mid-packet -> next cycle grant=0, fifo_wr=0, count=0. Watchdog build: owner stalls 255 cycles -> wd_abort pulse, grant=0.
